// File: rtl/opll_bus_writer_pkg.sv
// Shared types and constants for the OPLL bus writer.
// Build option: OPLL_BUS_WRITER_MEMMAP_EN selects memory-mapped cycles
// (7FF4h/7FF5h). Without it the writer issues I/O cycles to 7Ch/7Dh.
package opll_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_HOLD,
    ST_A_WAIT,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_HOLD,
    ST_D_WAIT
  } opll_wr_state_t;

  localparam logic [7:0]  OPLL_IO_BASE  = 8'h7C;
  localparam logic [15:0] OPLL_MEM_BASE = 16'h7FF4;

  typedef struct packed {
    logic [7:0] reg_idx;
    logic [7:0] data;
  } opll_req_t;

  // Bus address of the OPLL address port (is_data=0) or data port (is_data=1)
  function automatic logic [15:0] opll_port_addr(input logic is_data);
`ifdef OPLL_BUS_WRITER_MEMMAP_EN
    return OPLL_MEM_BASE + {15'd0, is_data};
`else
    return {8'h00, OPLL_IO_BASE + {7'd0, is_data}};
`endif
  endfunction

endpackage

// File: rtl/opll_bus_writer_if.sv
// Request handshake and cartridge-bus signals of the OPLL bus writer.
// master: the writer itself; slave: producer plus bus observer.
interface opll_bus_writer_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [7:0]  REQ_REG;
  logic [7:0]  REQ_DATA;
  logic        BUSY;
  logic [15:0] ADDR;
  logic [7:0]  DOUT;
  logic        IORQ_n;
  logic        MERQ_n;
  logic        SLTSL_n;
  logic        WR_n;
  logic        RD_n;

  modport master (
    input  REQ_VALID, REQ_REG, REQ_DATA,
    output REQ_READY, BUSY, ADDR, DOUT, IORQ_n, MERQ_n, SLTSL_n, WR_n, RD_n
  );

  modport slave (
    output REQ_VALID, REQ_REG, REQ_DATA,
    input  REQ_READY, BUSY, ADDR, DOUT, IORQ_n, MERQ_n, SLTSL_n, WR_n, RD_n
  );
endinterface

// File: rtl/opll_bus_writer_req_fifo.sv
// Request FIFO: synchronous, power-of-two depth, pointers wrap naturally.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module opll_req_fifo
  import opll_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      CLK,
  input  logic      RESET_n,
  input  logic      i_push,
  input  logic      i_pop,
  input  opll_req_t i_din,
  output opll_req_t o_head,
  output logic      o_full,
  output logic      o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  opll_req_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_en;
  logic          w_pop_en;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_FULL);
  assign w_pop_en  = i_pop && !o_empty;
  assign w_push_en = i_push && (!o_full || w_pop_en);
  assign o_head    = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge CLK) begin
    if (w_push_en) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers and occupancy; reset flushes the queue
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/opll_bus_writer.sv
// OPLL register writer: queues (reg, data) pairs and plays each out as an
// address-port write followed by a data-port write, padding both with the
// OPLL recovery time.
// Build option: OPLL_BUS_WRITER_MEMMAP_EN -> memory cycles at 7FF4h/7FF5h
// selected by MERQ_n+SLTSL_n; otherwise I/O cycles at 7Ch/7Dh via IORQ_n.
//
// state      | meaning
// IDLE       | nothing in flight, waiting for a queued request
// A_SETUP    | address port, register index on DOUT, select low, WR_n high
// A_STROBE   | as A_SETUP with WR_n low
// A_HOLD     | WR_n high again, address/data/select held
// A_WAIT     | select released, OPLL address-write recovery
// D_SETUP    | data port, register value on DOUT, select low, WR_n high
// D_STROBE   | as D_SETUP with WR_n low
// D_HOLD     | WR_n high again, address/data/select held
// D_WAIT     | select released, OPLL data-write recovery
module opll_bus_writer
  import opll_bus_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYC     = 2,
  parameter int STROBE_CYC    = 4,
  parameter int HOLD_CYC      = 2,
  parameter int ADDR_WAIT_CYC = 96,
  parameter int DATA_WAIT_CYC = 648
) (
  input  logic               CLK,
  input  logic               RESET_n,
  opll_bus_writer_if.master  bus
);
  localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CD  = (HOLD_CYC > ADDR_WAIT_CYC) ? HOLD_CYC : ADDR_WAIT_CYC;
  localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_CYC = (MAX_ABC > DATA_WAIT_CYC) ? MAX_ABC : DATA_WAIT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  opll_wr_state_t r_state;
  opll_wr_state_t w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           w_last;
  logic           w_pop;
  logic           w_push;
  logic           w_full;
  logic           w_empty;
  opll_req_t      w_head;
  opll_req_t      w_push_req;
  opll_req_t      r_req;
  opll_req_t      w_req_nxt;
  logic           r_ready;
  logic [15:0]    r_addr;
  logic [15:0]    w_addr_nxt;
  logic [7:0]     r_dout;
  logic [7:0]     w_dout_nxt;
  logic           r_sel_n;
  logic           w_sel_n_nxt;
  logic           r_wr_n;
  logic           w_wr_n_nxt;

  // Counter preload for each phase: a phase of N cycles counts N-1 down to 0
  function automatic logic [CW-1:0] phase_load(input opll_wr_state_t s);
    case (s)
      ST_A_SETUP, ST_D_SETUP:   phase_load = CW'(SETUP_CYC - 1);
      ST_A_STROBE, ST_D_STROBE: phase_load = CW'(STROBE_CYC - 1);
      ST_A_HOLD, ST_D_HOLD:     phase_load = CW'(HOLD_CYC - 1);
      ST_A_WAIT:                phase_load = CW'(ADDR_WAIT_CYC - 1);
      ST_D_WAIT:                phase_load = CW'(DATA_WAIT_CYC - 1);
      default:                  phase_load = '0;
    endcase
  endfunction

  assign w_push_req = '{reg_idx: bus.REQ_REG, data: bus.REQ_DATA};
  assign w_push     = bus.REQ_VALID && bus.REQ_READY;

  opll_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_req),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // READY stays low through reset and comes up on the first clock after release
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) r_ready <= 1'b0;
    else          r_ready <= 1'b1;
  end

  // State register, phase counter and the working copy of the active request
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
    end
  end

  // Next state: walk the phases, chaining straight into the next request after D_WAIT
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_last      = (r_cnt == '0);
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_A_SETUP;
        end
      end
      ST_A_SETUP:  if (w_last) w_state_nxt = ST_A_STROBE;
      ST_A_STROBE: if (w_last) w_state_nxt = ST_A_HOLD;
      ST_A_HOLD:   if (w_last) w_state_nxt = ST_A_WAIT;
      ST_A_WAIT:   if (w_last) w_state_nxt = ST_D_SETUP;
      ST_D_SETUP:  if (w_last) w_state_nxt = ST_D_STROBE;
      ST_D_STROBE: if (w_last) w_state_nxt = ST_D_HOLD;
      ST_D_HOLD:   if (w_last) w_state_nxt = ST_D_WAIT;
      ST_D_WAIT: begin
        if (w_last) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_A_SETUP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = phase_load(w_state_nxt);
    else if (!w_last)           w_cnt_nxt = r_cnt - CNT_ONE;
  end

  assign w_req_nxt = w_pop ? w_head : r_req;

  // Bus values for the state being entered, so the bus registers line up with it
  always_comb begin
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_sel_n_nxt = 1'b1;
    w_wr_n_nxt  = 1'b1;
    case (w_state_nxt)
      ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
        w_addr_nxt  = opll_port_addr(1'b0);
        w_dout_nxt  = w_req_nxt.reg_idx;
        w_sel_n_nxt = 1'b0;
        w_wr_n_nxt  = (w_state_nxt != ST_A_STROBE);
      end
      ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
        w_addr_nxt  = opll_port_addr(1'b1);
        w_dout_nxt  = w_req_nxt.data;
        w_sel_n_nxt = 1'b0;
        w_wr_n_nxt  = (w_state_nxt != ST_D_STROBE);
      end
      default: ;
    endcase
  end

  // Registered bus outputs; strobes go inactive asynchronously on reset
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_addr  <= '0;
      r_dout  <= '0;
      r_sel_n <= 1'b1;
      r_wr_n  <= 1'b1;
    end else begin
      r_addr  <= w_addr_nxt;
      r_dout  <= w_dout_nxt;
      r_sel_n <= w_sel_n_nxt;
      r_wr_n  <= w_wr_n_nxt;
    end
  end

  assign bus.REQ_READY = r_ready && !w_full;
  assign bus.BUSY      = (r_state != ST_IDLE) || !w_empty;
  assign bus.ADDR      = r_addr;
  assign bus.DOUT      = r_dout;
  assign bus.WR_n      = r_wr_n;
  assign bus.RD_n      = 1'b1;
`ifdef OPLL_BUS_WRITER_MEMMAP_EN
  assign bus.IORQ_n    = 1'b1;
  assign bus.MERQ_n    = r_sel_n;
  assign bus.SLTSL_n   = r_sel_n;
`else
  assign bus.IORQ_n    = r_sel_n;
  assign bus.MERQ_n    = 1'b1;
  assign bus.SLTSL_n   = 1'b1;
`endif
endmodule

// File: tb/tb_opll_bus_writer.sv
// Testbench for opll_bus_writer. Builds for either bus mode; define
// OPLL_BUS_WRITER_MEMMAP_EN to exercise memory-mapped cycles.
`timescale 1ns/1ps
module tb_opll_bus_writer;
  localparam int SETUP_CYC     = 2;
  localparam int STROBE_CYC    = 4;
  localparam int HOLD_CYC      = 2;
  localparam int ADDR_WAIT_CYC = 96;
  localparam int DATA_WAIT_CYC = 648;
  localparam int FIFO_DEPTH    = 4;
`ifdef OPLL_BUS_WRITER_MEMMAP_EN
  localparam logic [15:0] A_PORT = 16'h7FF4;
  localparam logic [15:0] D_PORT = 16'h7FF5;
  localparam bit MEMMAP = 1'b1;
`else
  localparam logic [15:0] A_PORT = 16'h007C;
  localparam logic [15:0] D_PORT = 16'h007D;
  localparam bit MEMMAP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET_n = 1'b0;
  always #5 CLK = ~CLK;

  opll_bus_writer_if bus();

  opll_bus_writer #(
    .FIFO_DEPTH(FIFO_DEPTH), .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC(HOLD_CYC), .ADDR_WAIT_CYC(ADDR_WAIT_CYC), .DATA_WAIT_CYC(DATA_WAIT_CYC)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: accepted requests in order, plus the OPLL register file they build up
  typedef struct { logic [7:0] r; logic [7:0] d; } req_t;
  req_t       exp_q[$];
  logic [7:0] opll_regs [256];
  logic [7:0] opll_idx = 8'h00;
  logic       pend_valid = 1'b0;
  logic [7:0] pend_r = 8'h00;

  // Captured bus writes
  logic [15:0] cap_addr[$];
  logic [7:0]  cap_dout[$];
  int          cap_fall[$];
  int          cap_rise[$];
  int          writes_total = 0;

  int   cyc = 0;
  always @(posedge CLK) cyc++;

  logic        p_wr = 1'b1;
  logic        p_sel = 1'b1;
  logic [15:0] p_addr = 16'h0;
  int          chg_cyc = 0;
  int          low_cnt = 0;
  int          wr_rise_cyc = 0;

  // Bus monitor: timing rules, select encoding and scoreboard at every strobe
  always @(negedge CLK) begin
    logic sel_n;
    req_t e;
    sel_n = MEMMAP ? bus.MERQ_n : bus.IORQ_n;
    if (!RESET_n) begin
      low_cnt    = 0;
      pend_valid = 1'b0;
    end else begin
      if ((bus.ADDR !== p_addr) || (sel_n !== p_sel)) begin
        if (sel_n === 1'b1 && p_sel === 1'b0)
          check("hold_cycles", cyc - wr_rise_cyc, HOLD_CYC);
        if (sel_n === 1'b0) chg_cyc = cyc;
      end
      if (p_wr === 1'b1 && bus.WR_n === 1'b0) begin
        low_cnt = 1;
        check("setup_cycles", cyc - chg_cyc, SETUP_CYC);
        check("select_low", sel_n, 1'b0);
        if (MEMMAP) check("other_selects", {bus.IORQ_n, bus.SLTSL_n, bus.RD_n}, 3'b101);
        else        check("other_selects", {bus.MERQ_n, bus.SLTSL_n, bus.RD_n}, 3'b111);
        cap_addr.push_back(bus.ADDR);
        cap_dout.push_back(bus.DOUT);
        cap_fall.push_back(cyc);
        writes_total++;
        if (bus.ADDR === A_PORT) begin
          pend_r     = bus.DOUT;
          pend_valid = 1'b1;
          opll_idx   = bus.DOUT;
        end else if (bus.ADDR === D_PORT) begin
          check("sb_addr_before_data", pend_valid, 1'b1);
          check("sb_expected_pending", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_reg", pend_r, e.r);
            check("sb_data", bus.DOUT, e.d);
          end
          opll_regs[opll_idx] = bus.DOUT;
          pend_valid = 1'b0;
        end else begin
          check("port_addr", bus.ADDR, A_PORT);
        end
      end else if (bus.WR_n === 1'b0) begin
        low_cnt++;
      end else if (p_wr === 1'b0 && bus.WR_n === 1'b1) begin
        check("strobe_len", low_cnt, STROBE_CYC);
        check("addr_stable", bus.ADDR, cap_addr[$]);
        check("select_held", sel_n, 1'b0);
        cap_rise.push_back(cyc);
        wr_rise_cyc = cyc;
        low_cnt = 0;
      end
    end
    p_wr   = bus.WR_n;
    p_sel  = sel_n;
    p_addr = bus.ADDR;
  end

  task automatic clear_caps();
    cap_addr.delete(); cap_dout.delete(); cap_fall.delete(); cap_rise.delete();
  endtask

  // Offer one request for one clock; acc reports whether it was taken
  task automatic push_req(input logic [7:0] r, input logic [7:0] d, output bit acc);
    req_t q;
    bus.REQ_VALID = 1'b1;
    bus.REQ_REG   = r;
    bus.REQ_DATA  = d;
    #1;
    acc = bus.REQ_READY;
    if (acc) begin
      q.r = r; q.d = d;
      exp_q.push_back(q);
    end
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic wait_rises(input int n, input int budget, input string nm);
    int k = 0;
    while (cap_rise.size() < n && k < budget) begin @(negedge CLK); k++; end
    check(nm, cap_rise.size() >= n, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (bus.BUSY !== 1'b0 && k < budget) begin @(negedge CLK); k++; end
    check(nm, bus.BUSY, 1'b0);
  endtask

  typedef struct {
    logic [7:0]  r;
    logic [7:0]  d;
    logic [15:0] ea_addr;
    logic [7:0]  ea_dout;
    logic [15:0] ed_addr;
    logic [7:0]  ed_dout;
  } vec_t;
  vec_t vt[5];

  initial begin
    bit acc;
    int n_acc;
    int busy_fall;
    int w0;
    int k;

    vt[0] = '{8'h10, 8'h55, A_PORT, 8'h10, D_PORT, 8'h55};
    vt[1] = '{8'h01, 8'hAA, A_PORT, 8'h01, D_PORT, 8'hAA};
    vt[2] = '{8'h20, 8'h0F, A_PORT, 8'h20, D_PORT, 8'h0F};
    vt[3] = '{8'h30, 8'hA5, A_PORT, 8'h30, D_PORT, 8'hA5};
    vt[4] = '{8'h3F, 8'hFF, A_PORT, 8'h3F, D_PORT, 8'hFF};

    bus.REQ_VALID = 1'b0;
    bus.REQ_REG   = 8'h00;
    bus.REQ_DATA  = 8'h00;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_strobes", {bus.WR_n, bus.IORQ_n, bus.MERQ_n, bus.SLTSL_n, bus.RD_n}, 5'b11111);
    check("rst_addr", bus.ADDR, 16'h0000);
    check("rst_dout", bus.DOUT, 8'h00);
    check("rst_ready", bus.REQ_READY, 1'b0);
    check("rst_busy", bus.BUSY, 1'b0);
    RESET_n = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", bus.REQ_READY, 1'b1);

    // Single request: both writes, recovery gap, resulting OPLL register
    clear_caps();
    push_req(vt[0].r, vt[0].d, acc);
    check("t1_accept", acc, 1'b1);
    wait_rises(2, 2000, "t1_timeout");
    check("t1_a_addr", cap_addr[0], vt[0].ea_addr);
    check("t1_a_dout", cap_dout[0], vt[0].ea_dout);
    check("t1_d_addr", cap_addr[1], vt[0].ed_addr);
    check("t1_d_dout", cap_dout[1], vt[0].ed_dout);
    check("t1_a_to_d_gap", cap_fall[1] - cap_rise[0], 100);
    wait_idle(2000, "t1_idle");
    check("t6_opll_reg10", opll_regs[8'h10], 8'h55);

    // Four requests on four consecutive clocks
    clear_caps();
    for (int i = 1; i <= 4; i++) begin
      push_req(vt[i].r, vt[i].d, acc);
      check("t2_ready", acc, 1'b1);
    end
    wait_rises(8, 5000, "t2_timeout");
    for (int i = 0; i < 4; i++) begin
      check("t2_a_addr", cap_addr[2*i],   vt[i+1].ea_addr);
      check("t2_a_dout", cap_dout[2*i],   vt[i+1].ea_dout);
      check("t2_d_addr", cap_addr[2*i+1], vt[i+1].ed_addr);
      check("t2_d_dout", cap_dout[2*i+1], vt[i+1].ed_dout);
    end
    for (int i = 0; i < 3; i++)
      check("t2_d_to_a_gap", cap_fall[2*i+2] - cap_rise[2*i+1], 652);
    k = 0;
    while (bus.BUSY !== 1'b0 && k < 1000) begin @(negedge CLK); k++; end
    busy_fall = cyc;
    check("t2_busy_fall", busy_fall - cap_rise[7], HOLD_CYC + DATA_WAIT_CYC);
    check("t5_opll_reg30", opll_regs[8'h30], 8'hA5);

    // Overflow: six offers on consecutive clocks, one slot freed by the first pop
    clear_caps();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      push_req(8'h40 + 8'(i), 8'hC0 + 8'(i), acc);
      check("t3_accept", acc, (i < 5) ? 1'b1 : 1'b0);
      if (acc) n_acc++;
    end
    check("t3_accepted_count", n_acc, 5);
    wait_rises(10, 6000, "t3_timeout");
    wait_idle(2000, "t3_idle");
    check("t3_queue_drained", exp_q.size(), 0);
    check("t3_write_count", cap_addr.size(), 10);

    // Reset while the first request sits in A_WAIT with a second one queued
    clear_caps();
    push_req(8'h11, 8'h22, acc);
    push_req(8'h12, 8'h23, acc);
    wait_rises(1, 200, "t4_timeout");
    repeat (10) @(negedge CLK);
    #2 RESET_n = 1'b0;
    #1;
    check("t4_strobes", {bus.WR_n, bus.IORQ_n, bus.MERQ_n, bus.SLTSL_n}, 4'b1111);
    check("t4_busy", bus.BUSY, 1'b0);
    exp_q.delete();
    w0 = writes_total;
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    repeat (1000) @(negedge CLK);
    check("t4_no_write_after_rst", writes_total, w0);
    check("t4_busy_idle", bus.BUSY, 1'b0);
    push_req(8'h22, 8'h33, acc);
    k = 0;
    while (writes_total < w0 + 2 && k < 2000) begin @(negedge CLK); k++; end
    check("t4_new_writes", writes_total, w0 + 2);
    wait_idle(2000, "t4_idle");
    check("t4_opll_reg22", opll_regs[8'h22], 8'h33);

    // Random traffic against the scoreboard
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 300)) @(negedge CLK);
      push_req(8'($urandom), 8'($urandom), acc);
    end
    k = 0;
    while ((exp_q.size() != 0 || bus.BUSY !== 1'b0) && k < 8000) begin @(negedge CLK); k++; end
    check("rnd_queue_drained", exp_q.size(), 0);
    check("rnd_idle", bus.BUSY, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
